baud_frac_gen: RTL and testbench
================================

# baud_frac_gen

Programmable fractional-N oversampling baud generator for the UART path. It produces an oversample `tick` (nominally 16× baud) and a once-per-bit `bit_tick` from the system clock. The divisor can be reloaded at run time without glitching, and `clear` lets the receiver re-align the tick phase on a start-bit edge. It feeds both UART RX and TX and replaces the fixed-divisor tick generator.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency.
- `BAUD`, 9600: reset-time baud rate.
- `OVERSAMPLE`, 16: ticks per bit; power of two, ≥2.
- `DIV_W`, 16: integer divisor width.
- `FRAC_W`, 4: fractional divisor width.
- Reset divisor: round(CLK_HZ·2^FRAC_W/(BAUD·OVERSAMPLE)), split into integer and fraction parts (100 MHz/9600/16 → int 651, frac 1).
- Parameter constraint: the reset integer part must be ≥2 and fit in DIV_W, otherwise elaboration fails.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low (asserted at 0).
- `enable` in 1: count enable.
- `clear` in 1: synchronous phase restart.
- `div_load` in 1: single-cycle divisor write strobe.
- `div_int` in DIV_W: integer divisor, valid when `div_load`=1.
- `div_frac` in FRAC_W: fractional divisor, in 1/2^FRAC_W units.
- `tick` out 1: oversample tick, one cycle wide.
- `bit_tick` out 1: asserted with the tick that wraps `phase`.
- `phase` out log2(OVERSAMPLE): tick index within the bit.
- `div_pending` out 1: a loaded divisor is waiting to be applied.
- `div_err` out 1: one-cycle pulse flagging a rejected load.

## Operation
- State:
  - down-counter `cnt` (DIV_W bits)
  - fraction accumulator `acc` (FRAC_W bits)
  - active divisor (int, frac)
  - shadow divisor plus pending flag
  - `phase` counter
- Reset values: `cnt` = reset int − 1; `acc`, `phase`, `tick`, `bit_tick`, `div_pending`, `div_err` all 0; active and shadow = reset divisor.
- Enabled cycle with `cnt` ≠ 0: `cnt` decrements.
- Enabled cycle with `cnt` = 0 (terminal):
  - `tick` is set to 1.
  - {carry, acc} ← acc + active_frac.
  - `cnt` reloads to active_int − 1 + carry.
  - `phase` increments mod OVERSAMPLE; `bit_tick` is set to 1 when `phase` wraps from OVERSAMPLE−1 to 0.
- Pending divisor at terminal:
  - The reload and accumulation use the shadow divisor, which becomes active.
  - `acc` is cleared before the add.
  - `div_pending` clears.
- `enable`=0: `cnt`, `acc` and `phase` hold; `tick` and `bit_tick` are 0.
- Load with `div_int` ≥ 2: shadow ← (`div_int`, `div_frac`), `div_pending` ← 1. When a value is already pending, the last load wins.
- Load with `div_int` < 2: shadow is unchanged and `div_err` pulses for one cycle.
- `clear` (priority over `enable`):
  - `phase` ← 0, `acc` ← 0, `tick` and `bit_tick` ← 0.
  - A pending shadow is applied immediately and `div_pending` clears.
  - `cnt` ← active_int − 1, using the newly active value.
- Simultaneous events:
  - Load and terminal in the same cycle: the reload uses the old divisor; the new value stays pending until the next terminal.
  - Load and clear in the same cycle: the load captures first, then clear applies it.
- Exactness: over 2^FRAC_W consecutive ticks, total cycles = 2^FRAC_W·int + frac.

## Timing
- All outputs are registered; no combinational paths from input to output.
- After `reset` deasserts with `enable`=1, the first `tick` is high in cycle D, where D = reset int (frac contribution starts from `acc`=0).
- Steady-state tick period is int or int+1 cycles; the +1 occurs on the ticks where the accumulator carries.
- `bit_tick` coincides with every OVERSAMPLE-th `tick`.
- `div_err` and `div_pending` update in the cycle after the `div_load` edge.
- After `clear`, the first `tick` appears active_int enabled cycles later.
- Asserting `reset` mid-period zeroes all outputs immediately (asynchronously) and discards any pending divisor.

## Structure
- Shared package `uart_pkg` holds:
  - the function computing the reset int/frac split from CLK_HZ, BAUD, OVERSAMPLE and FRAC_W
  - the default OVERSAMPLE constant
- Sub-module `frac_accum` is natural: the acc/carry adder with its clear input, reusable by a future TX-only divider.
- Everything else lives in `baud_frac_gen`.

## Test plan
Bench uses OVERSAMPLE=16, FRAC_W=4.
1. Reset, then load int=4, frac=0, and wait for the apply → `tick` every 4 cycles, `bit_tick` every 64 cycles, `phase` cycles 0..15.
2. Load int=4, frac=8 → tick periods alternate 4, 5, 4, 5; 16 ticks span exactly 72 cycles.
3. Load int=1 → `div_err` high for one cycle, `div_pending` stays 0, tick period unchanged.
4. With int=10, load int=6 at count 5 → `div_pending`=1, the current 10-cycle period completes, following periods are 6, `div_pending` drops at that terminal.
5. `clear` mid-bit with int=4 → `tick` 0, `phase`=0, next `tick` exactly 4 cycles later; a pending load is applied at the clear.
6. `enable`=0 for 7 cycles mid-period → no ticks and the period is stretched by 7. Assert `reset` mid-period → all outputs 0 asynchronously; after release the divisor is back to the reset value.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and helpers for the UART datapath.
//   DEFAULT_OVERSAMPLE : oversample ticks per bit used when a block does not
//                        override it.
//   reset_divisor()    : rounded fixed-point divisor
//                        round(clk_hz * 2^frac_w / (baud * oversample)).
//                        The integer part is result >> frac_w and the
//                        fraction is the low frac_w bits.
package uart_pkg;

  localparam int unsigned DEFAULT_OVERSAMPLE = 16;

  function automatic longint unsigned reset_divisor(
    input longint unsigned clk_hz,
    input longint unsigned baud,
    input longint unsigned oversample,
    input int unsigned     frac_w
  );
    longint unsigned num;
    longint unsigned den;
    num = clk_hz << frac_w;
    den = baud * oversample;
    // Round to nearest: (2*num + den) / (2*den).
    return ((2 * num) + den) / (2 * den);
  endfunction

endpackage

// File: rtl/frac_accum.sv
// frac_accum: fractional accumulator for a fractional-N divider.
//   clk     in  : clock, rising edge
//   reset   in  : asynchronous, active-low
//   clear   in  : synchronous zero of the accumulator (wins over step)
//   step    in  : accumulate addend this cycle
//   restart in  : treat the accumulator as zero for this add (divisor swap)
//   addend  in  : fractional divisor, FRAC_W bits
//   carry   out : carry out of the current add (combinational, valid with step)
module frac_accum #(
  parameter int unsigned FRAC_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              step,
  input  logic              restart,
  input  logic [FRAC_W-1:0] addend,
  output logic              carry
);

  logic [FRAC_W-1:0] acc;
  logic [FRAC_W-1:0] base;
  logic [FRAC_W:0]   sum;

  always_comb begin
    base  = restart ? '0 : acc;
    sum   = {1'b0, base} + {1'b0, addend};
    carry = sum[FRAC_W];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (step) begin
      acc <= sum[FRAC_W-1:0];
    end
  end

endmodule

// File: rtl/baud_frac_gen.sv
// baud_frac_gen: programmable fractional-N oversampling baud generator.
//   clk         in  : system clock, rising edge
//   reset       in  : asynchronous, active-low
//   enable      in  : count enable
//   clear       in  : synchronous phase restart (priority over enable)
//   div_load    in  : one-cycle divisor write strobe
//   div_int     in  : integer divisor (must be >= 2 to be accepted)
//   div_frac    in  : fractional divisor in 1/2^FRAC_W units
//   tick        out : oversample tick, one cycle wide
//   bit_tick    out : tick on which phase wraps to 0
//   phase       out : tick index within the bit
//   div_pending out : a loaded divisor waits for the next terminal count
//   div_err     out : one-cycle pulse for a rejected load
module baud_frac_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FRAC_W     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          clear,
  input  logic                          div_load,
  input  logic [DIV_W-1:0]              div_int,
  input  logic [FRAC_W-1:0]             div_frac,
  output logic                          tick,
  output logic                          bit_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] phase,
  output logic                          div_pending,
  output logic                          div_err
);

  localparam longint unsigned RST_DIV   = reset_divisor(CLK_HZ, BAUD, OVERSAMPLE, FRAC_W);
  localparam longint unsigned RST_INT_L = RST_DIV >> FRAC_W;
  localparam logic [DIV_W-1:0]  RST_INT  = DIV_W'(RST_INT_L);
  localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(RST_DIV);

  if (RST_INT_L < 64'd2 || RST_INT_L > ((64'd1 << DIV_W) - 64'd1)) begin : g_bad_reset_div
    $error("baud_frac_gen: reset integer divisor must be >= 2 and fit in DIV_W");
  end

  if (OVERSAMPLE < 2 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_oversample
    $error("baud_frac_gen: OVERSAMPLE must be a power of two >= 2");
  end

  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  act_int;
  logic [FRAC_W-1:0] act_frac;
  logic [DIV_W-1:0]  sh_int;
  logic [FRAC_W-1:0] sh_frac;

  logic              load_ok;
  logic              terminal;
  logic              use_shadow;
  logic              carry;
  logic [FRAC_W-1:0] addend;
  logic [DIV_W-1:0]  rel_int;
  logic [DIV_W-1:0]  clr_int;
  logic [FRAC_W-1:0] clr_frac;

  always_comb begin
    load_ok    = div_load && (div_int >= DIV_W'(2));
    terminal   = enable && !clear && (cnt == '0);
    // A divisor pending before this edge is swapped in at the terminal; a
    // load arriving on the same edge only becomes pending.
    use_shadow = terminal && div_pending;
    addend     = use_shadow ? sh_frac : act_frac;
    rel_int    = use_shadow ? sh_int  : act_int;
    // On clear, a same-cycle load is captured first and applied directly.
    if (load_ok) begin
      clr_int  = div_int;
      clr_frac = div_frac;
    end else if (div_pending) begin
      clr_int  = sh_int;
      clr_frac = sh_frac;
    end else begin
      clr_int  = act_int;
      clr_frac = act_frac;
    end
  end

  frac_accum #(
    .FRAC_W (FRAC_W)
  ) u_frac_accum (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .step    (terminal),
    .restart (use_shadow),
    .addend  (addend),
    .carry   (carry)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= RST_INT - DIV_W'(1);
      act_int     <= RST_INT;
      act_frac    <= RST_FRAC;
      sh_int      <= RST_INT;
      sh_frac     <= RST_FRAC;
      div_pending <= 1'b0;
      phase       <= '0;
      tick        <= 1'b0;
      bit_tick    <= 1'b0;
      div_err     <= 1'b0;
    end else begin
      div_err <= div_load && !load_ok;
      if (load_ok) begin
        sh_int  <= div_int;
        sh_frac <= div_frac;
      end

      if (clear) begin
        act_int     <= clr_int;
        act_frac    <= clr_frac;
        cnt         <= clr_int - DIV_W'(1);
        div_pending <= 1'b0;
        phase       <= '0;
        tick        <= 1'b0;
        bit_tick    <= 1'b0;
      end else if (terminal) begin
        tick     <= 1'b1;
        bit_tick <= (phase == '1);
        phase    <= phase + 1'b1;
        cnt      <= rel_int - DIV_W'(1) + DIV_W'(carry);
        if (use_shadow) begin
          act_int  <= sh_int;
          act_frac <= sh_frac;
        end
        div_pending <= load_ok;
      end else begin
        tick     <= 1'b0;
        bit_tick <= 1'b0;
        if (enable) begin
          cnt <= cnt - DIV_W'(1);
        end
        if (load_ok) begin
          div_pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_baud_frac_gen.sv
// tb_baud_frac_gen: directed self-checking bench for baud_frac_gen.
// CLK_HZ=1 MHz, BAUD=9600, OVERSAMPLE=16, FRAC_W=4 gives a reset divisor of
// round(16e6/153600) = 104 sixteenths -> int 6, frac 8.
module tb_baud_frac_gen;

  localparam int OS    = 16;
  localparam int ONE   = 16;   // 2^FRAC_W
  localparam int RST_I = 6;
  localparam int RST_F = 8;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        clear;
  logic        div_load;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        tick;
  logic        bit_tick;
  logic [3:0]  phase;
  logic        div_pending;
  logic        div_err;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_on      = 0;

  baud_frac_gen #(
    .CLK_HZ     (1_000_000),
    .BAUD       (9600),
    .OVERSAMPLE (16),
    .DIV_W      (16),
    .FRAC_W     (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .clear       (clear),
    .div_load    (div_load),
    .div_int     (div_int),
    .div_frac    (div_frac),
    .tick        (tick),
    .bit_tick    (bit_tick),
    .phase       (phase),
    .div_pending (div_pending),
    .div_err     (div_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: rem = enabled cycles left until the next tick,
  // fraction kept as a plain integer with carry by comparison.
  int m_rem = RST_I, m_acc = 0, m_ai = RST_I, m_af = RST_F, m_si = RST_I, m_sf = RST_F;
  int m_phase = 0;
  bit m_pend = 0, m_tick = 0, m_bit = 0, m_err = 0;

  always @(posedge clk or negedge reset) begin : model
    int r, a, ai, af, si, sf, ph;
    bit pd, tk, bt, er, ok;
    if (!reset) begin
      m_rem <= RST_I; m_acc <= 0; m_ai <= RST_I; m_af <= RST_F;
      m_si <= RST_I; m_sf <= RST_F; m_pend <= 0; m_phase <= 0;
      m_tick <= 0; m_bit <= 0; m_err <= 0;
    end else begin
      r = m_rem; a = m_acc; ai = m_ai; af = m_af; si = m_si; sf = m_sf;
      ph = m_phase; pd = m_pend;
      ok = div_load && (int'(div_int) >= 2);
      er = div_load && !ok;
      tk = 0; bt = 0;
      if (clear) begin
        if (ok) begin ai = int'(div_int); af = int'(div_frac); end
        else if (pd) begin ai = si; af = sf; end
        if (ok) begin si = int'(div_int); sf = int'(div_frac); end
        pd = 0; a = 0; ph = 0; r = ai;
      end else begin
        if (enable) begin
          r = r - 1;
          if (r == 0) begin
            tk = 1;
            if (pd) begin ai = si; af = sf; a = 0; pd = 0; end
            a  = a + af;
            r  = ai + ((a >= ONE) ? 1 : 0);
            a  = a % ONE;
            ph = (ph + 1) % OS;
            bt = (ph == 0);
          end
        end
        if (ok) begin si = int'(div_int); sf = int'(div_frac); pd = 1; end
      end
      m_rem <= r; m_acc <= a; m_ai <= ai; m_af <= af; m_si <= si; m_sf <= sf;
      m_phase <= ph; m_pend <= pd; m_tick <= tk; m_bit <= bt; m_err <= er;
    end
  end

  task automatic cmp(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("tick",        int'(tick),        int'(m_tick));
      cmp("bit_tick",    int'(bit_tick),    int'(m_bit));
      cmp("phase",       int'(phase),       m_phase);
      cmp("div_pending", int'(div_pending), int'(m_pend));
      cmp("div_err",     int'(div_err),     int'(m_err));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int i, input int f);
    div_int  = 16'(i);
    div_frac = 4'(f);
    div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
  endtask

  // Counts negedges until tick is seen high; ends on a tick negedge.
  task automatic measure(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 300);
    if (!tick) cmp("tick_timeout", 0, 1);
  endtask

  task automatic wait_applied();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (div_pending && n < 300);
    if (div_pending) cmp("apply_timeout", 0, 1);
  endtask

  initial begin : stim
    int p, sum, n;
    enable = 0; clear = 0; div_load = 0; div_int = '0; div_frac = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    chk_on = 1;

    // Reset state
    step(3);
    cmp("rst_tick", int'(tick), 0);
    cmp("rst_bit_tick", int'(bit_tick), 0);
    cmp("rst_phase", int'(phase), 0);
    cmp("rst_pending", int'(div_pending), 0);
    cmp("rst_err", int'(div_err), 0);

    // First tick after release at D = 6, then 6, 7 from frac 8
    reset = 1'b1; enable = 1'b1;
    measure(p); cmp("first_tick", p, 6);
    measure(p); cmp("rst_period_a", p, 6);
    measure(p); cmp("rst_period_b", p, 7);

    // 1: int 4 frac 0
    load(4, 0);
    cmp("load4_pending", int'(div_pending), 1);
    wait_applied();
    for (int i = 0; i < 4; i++) begin
      measure(p); cmp("period4", p, 4);
    end
    n = 0;
    while (!bit_tick && n < 200) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (!bit_tick && n < 200);
    cmp("bit_period", n, 64);

    // 2: int 4 frac 8 -> 4,5,4,5..., 16 ticks in 72 cycles
    load(4, 8);
    wait_applied();
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      measure(p);
      if (i == 0) cmp("frac_p0", p, 4);
      if (i == 1) cmp("frac_p1", p, 5);
      sum += p;
    end
    cmp("span16", sum, 72);

    // 3: rejected load
    load(1, 3);
    cmp("bad_err", int'(div_err), 1);
    cmp("bad_pending", int'(div_pending), 0);
    step(1);
    cmp("bad_err_drop", int'(div_err), 0);
    measure(p);
    measure(p); sum = p;
    measure(p); sum += p;
    cmp("bad_unchanged", sum, 9);

    // 4: reload mid-period
    load(10, 0);
    wait_applied();
    step(4);
    load(6, 0);
    cmp("mid_pending", int'(div_pending), 1);
    measure(p);
    cmp("old_period", 5 + p, 10);
    cmp("pending_drop", int'(div_pending), 0);
    measure(p); cmp("new_period", p, 6);

    // 5: clear on what would be the terminal cycle
    load(4, 0);
    wait_applied();
    step(3);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    cmp("clr_tick", int'(tick), 0);
    cmp("clr_phase", int'(phase), 0);
    measure(p); cmp("clr_period", p, 4);
    load(5, 0);
    cmp("clr_load_pending", int'(div_pending), 1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    cmp("clr_applied", int'(div_pending), 0);
    measure(p); cmp("clr_new_period", p, 5);

    // 6: enable gap stretches the period by 7
    step(2);
    enable = 1'b0;
    step(7);
    enable = 1'b1;
    measure(p);
    cmp("stretch", 2 + 7 + p, 12);

    // Async reset mid-period with a pending divisor
    load(7, 0);
    cmp("pre_rst_pending", int'(div_pending), 1);
    #1 reset = 1'b0;
    #1;
    cmp("arst_tick", int'(tick), 0);
    cmp("arst_bit_tick", int'(bit_tick), 0);
    cmp("arst_phase", int'(phase), 0);
    cmp("arst_pending", int'(div_pending), 0);
    cmp("arst_err", int'(div_err), 0);
    step(2);
    reset = 1'b1;
    measure(p); cmp("rerst_first", p, 6);
    measure(p); cmp("rerst_a", p, 6);
    measure(p); cmp("rerst_b", p, 7);

    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1);
  end

endmodule
